// File: rtl/my_fifo_pkg.sv
// Shared types and sizing helpers for the my_fifo_plus FIFO.
package my_fifo_pkg;

  typedef enum logic {
    FWFT_MODE = 1'b0,
    REG_MODE  = 1'b1
  } fifo_mode_e;

  // Count must represent 0..DEPTH inclusive, hence DEPTH+1 states.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic fifo_mode_e mode_of(input int fwft);
    return (fwft != 0) ? FWFT_MODE : REG_MODE;
  endfunction

endpackage

// File: rtl/my_fifo_ctrl.sv
// Pointer/occupancy controller for my_fifo_plus: accept logic, count and status flags.
// Optional sticky error flags are built when MY_FIFO_PLUS_ERR_FLAGS_EN is defined.
module my_fifo_ctrl import my_fifo_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int CNT_W = cnt_w(DEPTH),
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_wren,
  input  logic             i_rden,
  input  logic [CNT_W-1:0] i_upp_th,
  input  logic [CNT_W-1:0] i_low_th,
  output logic             wr_acc,
  output logic             rd_acc,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_alm_full,
  output logic             o_alm_empty
`ifdef MY_FIFO_PLUS_ERR_FLAGS_EN
  ,
  output logic             o_ovf,
  output logic             o_udf
`endif
);

  // Wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full      = (o_count == CNT_W'(DEPTH));
  assign o_empty     = (o_count == '0);
  assign o_alm_full  = (o_count > i_upp_th);
  assign o_alm_empty = (o_count < i_low_th);

  // A full FIFO still takes a write when a read frees the slot this cycle.
  assign rd_acc = i_rden && !o_empty && !i_flush;
  assign wr_acc = i_wren && (!o_full || rd_acc) && !i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else if (i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_acc && !rd_acc)      o_count <= o_count + CNT_W'(1);
      else if (rd_acc && !wr_acc) o_count <= o_count - CNT_W'(1);
    end
  end

`ifdef MY_FIFO_PLUS_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else if (i_flush) begin
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      if (i_wren && !wr_acc) o_ovf <= 1'b1;
      if (i_rden && o_empty) o_udf <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/my_fifo_plus.sv
// Synchronous FIFO with runtime thresholds and FWFT or registered read.
// Define MY_FIFO_PLUS_ERR_FLAGS_EN to add sticky o_ovf/o_udf outputs.
module my_fifo_plus import my_fifo_pkg::*; #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  parameter int  FWFT   = 1,
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  output logic              o_full,
  output logic              o_alm_full,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  output logic              o_empty,
  output logic              o_alm_empty,
  input  logic [CNT_W-1:0]  i_upp_th,
  input  logic [CNT_W-1:0]  i_low_th,
  output logic [CNT_W-1:0]  o_count
`ifdef MY_FIFO_PLUS_ERR_FLAGS_EN
  ,
  output logic              o_ovf,
  output logic              o_udf
`endif
);

  localparam int         PTR_W = $clog2(DEPTH);
  localparam fifo_mode_e MODE  = mode_of(FWFT);

  logic             wr_acc, rd_acc;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  my_fifo_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PTR_W(PTR_W)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (i_flush),
    .i_wren      (i_wren),
    .i_rden      (i_rden),
    .i_upp_th    (i_upp_th),
    .i_low_th    (i_low_th),
    .wr_acc      (wr_acc),
    .rd_acc      (rd_acc),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .o_count     (o_count),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_alm_full  (o_alm_full),
    .o_alm_empty (o_alm_empty)
`ifdef MY_FIFO_PLUS_ERR_FLAGS_EN
    ,
    .o_ovf       (o_ovf),
    .o_udf       (o_udf)
`endif
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= i_wrdata;
  end

  if (MODE == FWFT_MODE) begin : g_fwft
    assign o_rddata  = mem[rd_ptr];
    assign o_rdvalid = !o_empty;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_q;
    logic              rv_q;

    // rd_acc is already masked by flush, so rv_q drops on a flush cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= '0;
        rv_q <= 1'b0;
      end else begin
        rv_q <= rd_acc;
        if (rd_acc) rd_q <= mem[rd_ptr];
      end
    end

    assign o_rddata  = rd_q;
    assign o_rdvalid = rv_q;
  end

endmodule

// File: tb/tb_my_fifo_plus.sv
// Scoreboard bench: a DEPTH=16 FWFT instance and a DEPTH=5 registered-read instance share stimulus.
`timescale 1ns/1ps
module tb_my_fifo_plus;

  logic       clk = 1'b0, rst = 1'b1, flush = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] wd = '0;
  logic [4:0] upp = 5'd16, low = 5'd0;
  always #5 clk = ~clk;

  logic       f0, af0, e0, ae0, v0, f1, af1, e1, ae1, v1;
  logic [7:0] d0, d1;
  logic [4:0] c0;
  logic [2:0] c1;
`ifdef MY_FIFO_PLUS_ERR_FLAGS_EN
  logic ov0, ud0, ov1, ud1;
`endif

  my_fifo_plus #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u0 (
    .clk(clk), .rst(rst), .i_flush(flush), .i_wren(wr), .i_wrdata(wd),
    .o_full(f0), .o_alm_full(af0), .i_rden(rd), .o_rddata(d0), .o_rdvalid(v0),
    .o_empty(e0), .o_alm_empty(ae0), .i_upp_th(upp), .i_low_th(low), .o_count(c0)
`ifdef MY_FIFO_PLUS_ERR_FLAGS_EN
    , .o_ovf(ov0), .o_udf(ud0)
`endif
  );

  my_fifo_plus #(.DATA_W(8), .DEPTH(5), .FWFT(0)) u1 (
    .clk(clk), .rst(rst), .i_flush(flush), .i_wren(wr), .i_wrdata(wd),
    .o_full(f1), .o_alm_full(af1), .i_rden(rd), .o_rddata(d1), .o_rdvalid(v1),
    .o_empty(e1), .o_alm_empty(ae1), .i_upp_th(upp[2:0]), .i_low_th(low[2:0]), .o_count(c1)
`ifdef MY_FIFO_PLUS_ERR_FLAGS_EN
    , .o_ovf(ov1), .o_udf(ud1)
`endif
  );

  // Reference model: plain queues of stored data plus the reads still owed to the monitor.
  int         dep [2] = '{16, 5};
  logic [7:0] mq  [2][$];
  logic [7:0] exq [2][$];
  bit         rv [2], ovf [2], udf [2];
  int         n_chk = 0, n_fail = 0;

  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_state(input int k);
    int n, ut, lt;
    logic [31:0] cnt;
    logic ful, emp, af, ae, vld;
    string t;
    n   = mq[k].size();
    ut  = (k == 0) ? int'(upp) : int'(upp[2:0]);
    lt  = (k == 0) ? int'(low) : int'(low[2:0]);
    t   = (k == 0) ? "u0" : "u1";
    cnt = (k == 0) ? 32'(c0) : 32'(c1);
    ful = (k == 0) ? f0 : f1;
    emp = (k == 0) ? e0 : e1;
    af  = (k == 0) ? af0 : af1;
    ae  = (k == 0) ? ae0 : ae1;
    vld = (k == 0) ? v0 : v1;
    ck({t, "_count"}, cnt, n);
    ck({t, "_full"}, ful, n == dep[k]);
    ck({t, "_empty"}, emp, n == 0);
    ck({t, "_alm_full"}, af, n > ut);
    ck({t, "_alm_empty"}, ae, n < lt);
    ck({t, "_rdvalid"}, vld, (k == 0) ? (n != 0) : rv[1]);
    if (k == 0 && n != 0) ck("u0_head", d0, mq[0][0]);
`ifdef MY_FIFO_PLUS_ERR_FLAGS_EN
    ck({t, "_ovf"}, (k == 0) ? ov0 : ov1, ovf[k]);
    ck({t, "_udf"}, (k == 0) ? ud0 : ud1, udf[k]);
`endif
  endtask

  task automatic model_step(input int k, input bit w, input logic [7:0] d, input bit r, input bit f);
    bit ra, wa;
    ra = r && (mq[k].size() > 0) && !f;
    wa = w && ((mq[k].size() < dep[k]) || ra) && !f;
    if (f) begin
      mq[k].delete();
      ovf[k] = 0;
      udf[k] = 0;
    end else begin
      if (w && !wa) ovf[k] = 1;
      if (r && mq[k].size() == 0) udf[k] = 1;
    end
    if (ra) exq[k].push_back(mq[k].pop_front());
    if (wa) mq[k].push_back(d);
    rv[k] = ra;
  endtask

  // One clock of stimulus; entered and left 1ns after a rising edge.
  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit f);
    wr = w; wd = d; rd = r; flush = f;
    #1;
    for (int k = 0; k < 2; k++) check_state(k);
    for (int k = 0; k < 2; k++) model_step(k, w, d, r, f);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr = 0; rd = 0; flush = 0;
    rst = 1'b1;
    #1;
    ck("rst_u0_empty", e0, 1);
    ck("rst_u0_count", c0, 0);
    ck("rst_u1_empty", e1, 1);
    ck("rst_u1_full", f1, 0);
    ck("rst_u1_rdvalid", v1, 0);
    ck("rst_u1_rddata", d1, 0);
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      exq[k].delete();
      rv[k] = 0; ovf[k] = 0; udf[k] = 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops expected read data whenever a DUT presents a read.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !flush && rd && v0) begin
        if (exq[0].size() == 0) ck("u0_unexpected_read", 1, 0);
        else ck("u0_rddata", d0, exq[0].pop_front());
      end
      if (!rst && v1) begin
        if (exq[1].size() == 0) ck("u1_unexpected_rdvalid", 1, 0);
        else ck("u1_rddata", d1, exq[1].pop_front());
      end
    end
  end

  initial begin
    do_reset();
    // Fill to full, then one dropped write.
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    ck("fill_full", f0, 1);
    ck("fill_count16", c0, 16);
    cyc(1, 8'hEE, 0, 0);
`ifdef MY_FIFO_PLUS_ERR_FLAGS_EN
    ck("drop_ovf", ov0, 1);
`endif
    // Simultaneous write and read on a full FIFO.
    cyc(1, 8'h77, 1, 0);
    ck("full_rw_count", c0, 16);
    for (int i = 0; i < 17; i++) cyc(0, 8'h00, 1, 0);

    // FWFT single-entry latency.
    do_reset();
    cyc(1, 8'hA5, 0, 0);
    ck("fwft_rdvalid", v0, 1);
    ck("fwft_rddata", d0, 8'hA5);
    cyc(0, 8'h00, 1, 0);
    ck("fwft_empty_after_read", e0, 1);

    // Registered-read back-to-back burst.
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1, 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);

    // Pointer wrap on the DEPTH=5 instance.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, 8'(8'h50 + i), 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0);

    // Thresholds, flush, then reset in the middle of a burst.
    do_reset();
    upp = 5'd3; low = 5'd2;
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h90 + i), 0, 0);
    ck("th_alm_full_at5", af0, 1);
    cyc(1, 8'hFF, 1, 1);
    ck("flush_count0", c0, 0);
    ck("flush_u1_count0", c1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hC0 + i), i > 1, 0);
    do_reset();
    cyc(0, 8'h00, 1, 0);

    // Randomized traffic with alternating fill/drain bias.
    for (int i = 0; i < 800; i++) begin
      int wp;
      bit w, r, f;
      wp = ((i / 100) % 2 == 0) ? 75 : 30;
      if ($urandom_range(0, 39) == 0) begin
        upp = 5'($urandom_range(0, 16));
        low = 5'($urandom_range(0, 16));
      end
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 79) == 0);
      cyc(w, 8'($urandom), r, f);
    end
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    ck("u0_scoreboard_drained", exq[0].size(), 0);
    ck("u1_scoreboard_drained", exq[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/my_fifo_plus.md
MY_FIFO_PLUS -- requirements
Module: my_fifo_plus

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (>=2; non-power-of-2 legal).
REQ-003 SHALL have parameter FWFT, default 1: 1 = first-word-fall-through; 0 = registered read, 1-cycle latency.
REQ-004 SHALL define CNT_W = $clog2(DEPTH+1), the width of count and threshold ports.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 i_flush  in  1  synchronous clear of contents.
REQ-008 i_wren  in  1  write request.
REQ-009 i_wrdata  in  DATA_W  write data.
REQ-010 o_full  out  1  full flag.
REQ-011 o_alm_full  out  1  count > i_upp_th.
REQ-012 i_rden  in  1  read request.
REQ-013 o_rddata  out  DATA_W  read data.
REQ-014 o_rdvalid  out  1  o_rddata valid.
REQ-015 o_empty  out  1  empty flag.
REQ-016 o_alm_empty  out  1  count < i_low_th.
REQ-017 i_upp_th, i_low_th  in  CNT_W  runtime thresholds.
REQ-018 o_count  out  CNT_W  current occupancy.

Function
REQ-019 SHALL accept a write (wr_acc) when i_wren && (!full || rd_acc) && !i_flush.
REQ-020 SHALL accept a read (rd_acc) when i_rden && !empty && !i_flush; there is no same-cycle bypass from write to read when empty.
REQ-021 SHALL advance the write and read pointers modulo DEPTH, wrapping DEPTH-1 -> 0.
REQ-022 SHALL update count +1 on write only, -1 on read only, and leave it unchanged on simultaneous accepted read and write, including when full.
REQ-023 SHALL make o_full = (count==DEPTH), o_empty = (count==0), and derive both flags from registered count only.
REQ-024 In FWFT=1: o_rddata = entry at the read pointer, o_rdvalid = !o_empty, combinationally.
REQ-025 In FWFT=0: o_rddata SHALL be registered on rd_acc, o_rdvalid SHALL pulse exactly one cycle after rd_acc, and o_rddata SHALL hold its value otherwise.
REQ-026 i_flush SHALL take priority: next cycle pointers=0, count=0, o_rdvalid=0; requests in the flush cycle are ignored.
REQ-027 Threshold comparisons SHALL be unsigned CNT_W-bit, and threshold changes SHALL take effect combinationally.
REQ-028 Writes when full without a read SHALL be dropped with memory and pointers unchanged; reads when empty SHALL be ignored.

Reset
REQ-029 SHALL clear on rst assertion, asynchronously: pointers=0, count=0, o_rdvalid=0, o_rddata register=0, error flags=0.
REQ-030 Memory array contents SHALL NOT be reset.
REQ-031 Reset mid-operation SHALL discard all contents; the first cycle after deassertion SHALL show o_empty=1, o_full=0, o_count=0.

Configuration
REQ-032 Macro MY_FIFO_PLUS_ERR_FLAGS_EN defined: SHALL add outputs o_ovf and o_udf (1 bit each).
REQ-033 o_ovf SHALL be set sticky on a dropped write, and o_udf on a read request while empty.
REQ-034 o_ovf and o_udf SHALL be cleared only by rst or i_flush.
REQ-035 Macro undefined: ports o_ovf/o_udf and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-036 SHALL place in package my_fifo_pkg: the clog2-based CNT_W helper function, and a typedef enum of mode values FWFT_MODE / REG_MODE.
REQ-037 SHALL use one sub-module, my_fifo_ctrl, holding the pointers, count, flags and accept logic; the top holds the storage array and read mux/register.

Verification
REQ-038 Reset, then DEPTH=16 writes of 0..15 with no reads -> o_full=1 and o_count=16; a 17th write is dropped and o_ovf=1 (macro on).
REQ-039 FWFT=1: write 0xA5 into an empty FIFO -> next cycle o_rdvalid=1, o_rddata=0xA5; assert i_rden -> o_empty=1 the following cycle.
REQ-040 FWFT=0: fill with 1,2,3, read three back-to-back -> o_rdvalid high for 3 cycles, each one cycle after its rd_acc, with data 1,2,3.
REQ-041 Full FIFO, simultaneous write 0x77 and read -> o_count stays 16; 0x77 is read out after the 15 older entries.
REQ-042 DEPTH=5: 12 write/read pairs -> pointers wrap correctly and data order is preserved across the wrap.
REQ-043 i_upp_th=3, i_low_th=2 while filling 0->5 -> o_alm_empty high at counts 0..1, o_alm_full high at counts 4..5; i_flush at count 5 -> o_count=0 next cycle; asserting rst mid-burst -> o_empty=1 immediately.
